// File: rtl/fifo_sync_param.sv
// Synchronous single-clock FIFO with registered read data, occupancy-decoded
// status flags and sticky overflow/underflow error flags.
module fifo_sync_param #(
  parameter int unsigned DATA_WIDTH       = 8,
  parameter int unsigned ADDR_WIDTH       = 3,
  parameter int unsigned ALMOST_EMPTY_LVL = 2,
  parameter int unsigned ALMOST_FULL_LVL  = 6
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  Enable,
  input  logic                  write_enable,
  input  logic                  read_enable,
  input  logic                  err_clear,
  input  logic [DATA_WIDTH-1:0] FIFO_data_in,
  output logic [DATA_WIDTH-1:0] FIFO_data_out,
  output logic                  FIFO_data_valid,
  output logic [ADDR_WIDTH:0]   FIFO_count,
  output logic                  FIFO_empty,
  output logic                  FIFO_full,
  output logic                  FIFO_almost_empty,
  output logic                  FIFO_almost_full,
  output logic                  FIFO_overflow,
  output logic                  FIFO_underflow
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  // Count thresholds at the count register's width.
  localparam logic [ADDR_WIDTH:0] CountFull = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AeLvl     = ALMOST_EMPTY_LVL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AfLvl     = ALMOST_FULL_LVL[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;

  logic rd_acc, wr_acc;

  // Status flags decoded straight from the count register.
  always_comb begin
    FIFO_empty        = (count_q == '0);
    FIFO_full         = (count_q == CountFull);
    FIFO_almost_empty = (count_q != '0) && (count_q <= AeLvl);
    FIFO_almost_full  = (count_q != CountFull) && (count_q >= AfLvl);
  end

  // Access acceptance; a read frees a slot so a write into a full FIFO can proceed.
  always_comb begin
    rd_acc = Enable & read_enable & ~FIFO_empty;
    wr_acc = Enable & write_enable & (~FIFO_full | rd_acc);
  end

  // Next-state for pointers, count, read data and sticky errors.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    ovf_d    = ovf_q;
    udf_d    = udf_q;

    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      data_d   = mem_q[rd_ptr_q];
      valid_d  = 1'b1;
    end
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Clear first so a coincident error condition wins.
    if (err_clear) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (Enable & write_enable & ~wr_acc) begin
      ovf_d = 1'b1;
    end
    if (Enable & read_enable & FIFO_empty) begin
      udf_d = 1'b1;
    end
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage array is never reset; writes are suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (Reset && wr_acc) begin
      mem_q[wr_ptr_q] <= FIFO_data_in;
    end
  end

  assign FIFO_data_out   = data_q;
  assign FIFO_data_valid = valid_q;
  assign FIFO_count      = count_q;
  assign FIFO_overflow   = ovf_q;
  assign FIFO_underflow  = udf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboard bench for fifo_sync_param: a queue-based reference model predicts
// read data and status; a monitor compares read data whenever the DUT strobes valid.
module tb_fifo_sync_param;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AE    = 2;
  localparam int AF    = 6;

  logic          clk;
  logic          Reset;
  logic          Enable;
  logic          write_enable;
  logic          read_enable;
  logic          err_clear;
  logic [DW-1:0] FIFO_data_in;
  logic [DW-1:0] FIFO_data_out;
  logic          FIFO_data_valid;
  logic [AW:0]   FIFO_count;
  logic          FIFO_empty;
  logic          FIFO_full;
  logic          FIFO_almost_empty;
  logic          FIFO_almost_full;
  logic          FIFO_overflow;
  logic          FIFO_underflow;

  fifo_sync_param #(
    .DATA_WIDTH      (DW),
    .ADDR_WIDTH      (AW),
    .ALMOST_EMPTY_LVL(AE),
    .ALMOST_FULL_LVL (AF)
  ) dut (
    .clk              (clk),
    .Reset            (Reset),
    .Enable           (Enable),
    .write_enable     (write_enable),
    .read_enable      (read_enable),
    .err_clear        (err_clear),
    .FIFO_data_in     (FIFO_data_in),
    .FIFO_data_out    (FIFO_data_out),
    .FIFO_data_valid  (FIFO_data_valid),
    .FIFO_count       (FIFO_count),
    .FIFO_empty       (FIFO_empty),
    .FIFO_full        (FIFO_full),
    .FIFO_almost_empty(FIFO_almost_empty),
    .FIFO_almost_full (FIFO_almost_full),
    .FIFO_overflow    (FIFO_overflow),
    .FIFO_underflow   (FIFO_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [DW-1:0] mq[$];     // stored entries, oldest first
  logic [DW-1:0] exp_q[$];  // scoreboard: read data the DUT must present
  logic [DW-1:0] m_dout;
  logic          m_valid;
  logic          m_ovf;
  logic          m_udf;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  task automatic check_status();
    int n;
    n = mq.size();
    chk("count", int'(FIFO_count), n);
    chk("empty", int'(FIFO_empty), int'(n == 0));
    chk("full", int'(FIFO_full), int'(n == DEPTH));
    chk("almost_empty", int'(FIFO_almost_empty), int'(n != 0 && n <= AE));
    chk("almost_full", int'(FIFO_almost_full), int'(n != DEPTH && n >= AF));
    chk("overflow", int'(FIFO_overflow), int'(m_ovf));
    chk("underflow", int'(FIFO_underflow), int'(m_udf));
    chk("data_valid", int'(FIFO_data_valid), int'(m_valid));
    chk("data_out", int'(FIFO_data_out), int'(m_dout));
  endtask

  // One clock cycle of normal operation; inputs change #1 after the rising edge.
  task automatic step(input logic en, input logic we, input logic re, input logic ec,
                      input logic [DW-1:0] din);
    logic rd, wr, ovf_set, udf_set;
    Reset        = 1'b1;
    Enable       = en;
    write_enable = we;
    read_enable  = re;
    err_clear    = ec;
    FIFO_data_in = din;
    rd      = en && re && (mq.size() != 0);
    wr      = en && we && ((mq.size() != DEPTH) || rd);
    ovf_set = en && we && !wr;
    udf_set = en && re && (mq.size() == 0);
    @(posedge clk);
    m_valid = rd;
    if (rd) begin
      m_dout = mq.pop_front();
      exp_q.push_back(m_dout);
    end
    if (wr) mq.push_back(din);
    m_ovf = ovf_set || (m_ovf && !ec);
    m_udf = udf_set || (m_udf && !ec);
    #1;
    check_status();
  endtask

  task automatic do_reset(input logic en, input logic we, input logic re);
    Reset        = 1'b0;
    Enable       = en;
    write_enable = we;
    read_enable  = re;
    err_clear    = 1'b0;
    FIFO_data_in = 8'hEE;
    @(posedge clk);
    mq.delete();
    m_dout  = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    #1;
    check_status();
  endtask

  // Monitor: every valid strobe consumes one scoreboard entry.
  initial begin
    forever begin
      @(negedge clk);
      if (FIFO_data_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_valid", 1, 0);
        end else begin
          chk("sb_data", int'(FIFO_data_out), int'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] d;
    Reset = 1'b0; Enable = 1'b0; write_enable = 1'b0; read_enable = 1'b0;
    err_clear = 1'b0; FIFO_data_in = '0;
    m_dout = '0; m_valid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    #1;
    do_reset(1'b0, 1'b0, 1'b0);
    do_reset(1'b1, 1'b1, 1'b1);

    // Fill 0x01..0x08, then drain in order.
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b1, 1'b0, 1'b0, DW'(i));
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);

    // Overflow while full, reads unaffected, error cleared.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 1'b0, DW'(8'h10 + i));
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'hAA);
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'hBB);  // full read+write: both accepted
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b1, '0);

    // Read+write while empty: write accepted, underflow set.
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'h55);
    step(1'b1, 1'b0, 1'b1, 1'b0, '0);
    // Error set coincident with clear must win.
    step(1'b1, 1'b0, 1'b1, 1'b1, '0);
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);  // clear works while disabled

    // Fill 5, then 20 cycles of simultaneous read/write across pointer wrap.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0, DW'(8'h20 + i));
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b1, 1'b0, DW'(8'h40 + i));
    // Disabled cycles hold everything.
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h77);
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h78);

    // Fill to 4 then reset with Enable low.
    do_reset(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, DW'(8'h60 + i));
    step(1'b1, 1'b0, 1'b1, 1'b0, '0);
    do_reset(1'b0, 1'b0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      d = DW'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        do_reset(1'($urandom), 1'($urandom), 1'($urandom));
      end else begin
        step(1'($urandom_range(0, 9) != 0), 1'($urandom), 1'($urandom),
             1'($urandom_range(0, 9) == 0), d);
      end
    end

    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
